reg_ctx_ctrl: RTL and testbench

REG_CTX_CTRL -- requirements
Module: reg_ctx_ctrl

---
 rtl/reg_ctx_ctrl.sv | 110 +++++++++++
 tb/tb_reg_ctx_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctx_ctrl.sv
// Register-file context save/restore sequencer: streams R0..LAST_REG out over a
// valid/ready port, or loads them back from an input stream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request while the CPU is idle
// SAVE    | presenting register idx on Out_Data, advance on Out_Ready
// RESTORE | writing In_Data into register idx, advance on In_Valid
// DONE    | one-cycle completion pulse, then back to IDLE
module reg_ctx_ctrl #(
  parameter logic [2:0] LAST_REG = 3'd7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Save_Req,
  input  logic        Restore_Req,
  input  logic        Abort,
  input  logic        Cpu_Idle,
  input  logic [15:0] SR2_out,
  output logic [15:0] Out_Data,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  input  logic [15:0] In_Data,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic        RF_Own,
  output logic        RF_LD_REG,
  output logic        RF_DR,
  output logic [2:0]  RF_IR_11to9,
  output logic [2:0]  RF_SR2,
  output logic [15:0] RF_Data_in,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t     state;
  logic [2:0] idx;
  logic       save_act;
  logic       rest_act;
  logic       done_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= 3'd0;
      save_act <= 1'b0;
      rest_act <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          idx <= 3'd0;
          if (Cpu_Idle && Save_Req) begin
            state    <= SAVE;
            save_act <= 1'b1;
          end else if (Cpu_Idle && Restore_Req) begin
            state    <= RESTORE;
            rest_act <= 1'b1;
          end
        end
        SAVE: begin
          // an abort still lets a word accepted in the same cycle count as consumed
          if (Abort || (Out_Ready && idx == LAST_REG)) begin
            idx      <= 3'd0;
            save_act <= 1'b0;
            state    <= Abort ? IDLE : DONE;
            done_q   <= !Abort;
          end else if (Out_Ready) begin
            idx <= idx + 3'd1;
          end
        end
        RESTORE: begin
          if (Abort || (In_Valid && idx == LAST_REG)) begin
            idx      <= 3'd0;
            rest_act <= 1'b0;
            state    <= Abort ? IDLE : DONE;
            done_q   <= !Abort;
          end else if (In_Valid) begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          idx   <= 3'd0;
          state <= IDLE;
        end
        default: begin
          idx   <= 3'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // data paths are gated by the registered mode flags so idle outputs read zero
  assign Out_Valid   = save_act;
  assign In_Ready    = rest_act;
  assign Busy        = save_act | rest_act;
  assign RF_Own      = save_act | rest_act;
  assign Done        = done_q;
  assign RF_DR       = 1'b0;
  assign RF_SR2      = save_act ? idx : 3'd0;
  assign Out_Data    = save_act ? SR2_out : 16'd0;
  assign RF_IR_11to9 = rest_act ? idx : 3'd0;
  assign RF_Data_in  = rest_act ? In_Data : 16'd0;
  assign RF_LD_REG   = rest_act & In_Valid;

endmodule

// File: tb/tb_reg_ctx_ctrl.sv
// Scoreboard bench for reg_ctx_ctrl with a behavioural 8x16 register file.
module tb_reg_ctx_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Save_Req, Restore_Req, Abort, Cpu_Idle;
  logic        Out_Ready, In_Valid;
  logic [15:0] SR2_out, In_Data, Out_Data, RF_Data_in;
  logic        Out_Valid, In_Ready, RF_Own, RF_LD_REG, RF_DR, Busy, Done;
  logic [2:0]  RF_IR_11to9, RF_SR2;

  logic [15:0] rf [8];
  logic        pre_en;
  logic [15:0] pre_base;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [15:0] save_q [$];
  logic [18:0] wr_q [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'd0;

  reg_ctx_ctrl #(.LAST_REG(3'd7)) dut (
    .Clk(Clk), .Reset(Reset), .Save_Req(Save_Req), .Restore_Req(Restore_Req),
    .Abort(Abort), .Cpu_Idle(Cpu_Idle), .SR2_out(SR2_out), .Out_Data(Out_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .In_Data(In_Data),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .RF_Own(RF_Own),
    .RF_LD_REG(RF_LD_REG), .RF_DR(RF_DR), .RF_IR_11to9(RF_IR_11to9),
    .RF_SR2(RF_SR2), .RF_Data_in(RF_Data_in), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign SR2_out = rf[RF_SR2];

  always @(posedge Clk) begin
    if (pre_en) begin
      for (int i = 0; i < 8; i++) rf[i] <= pre_base + 16'(i);
    end else if (RF_LD_REG) begin
      rf[RF_IR_11to9] <= RF_Data_in;
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops expected words whenever the DUT completes a handshake
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
      check("ld_outside_restore", 48'(RF_LD_REG & ~In_Ready), 48'd0);
      if (prev_stall && Out_Valid) check("stall_stable", 48'(Out_Data), 48'(prev_data));
      if (Out_Valid && Out_Ready) begin
        if (save_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL save_unexpected: got %0h expected no word", Out_Data);
        end else check("save_word", 48'(Out_Data), 48'(save_q.pop_front()));
      end
      if (RF_LD_REG) begin
        if (wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL write_unexpected: got %0h@%0d expected no write", RF_Data_in, RF_IR_11to9);
        end else check("restore_write", 48'({RF_IR_11to9, RF_Data_in}), 48'(wr_q.pop_front()));
      end
    end
    prev_stall = Out_Valid && !Out_Ready;
    prev_data  = Out_Data;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge Clk);
      cyc++;
      if (Done) break;
      if (cyc >= max) begin
        check("done_timeout", 48'd0, 48'd1);
        break;
      end
    end
  endtask

  task automatic preload(input logic [15:0] base);
    pre_base = base;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  function automatic logic [47:0] all_outs();
    return 48'({Out_Valid, In_Ready, RF_LD_REG, RF_Own, Busy, Done, RF_DR,
                RF_SR2, RF_IR_11to9, Out_Data, RF_Data_in});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int sent;
    bit seen;
    Reset = 1'b1; Save_Req = 1'b0; Restore_Req = 1'b0; Abort = 1'b0;
    Cpu_Idle = 1'b1; Out_Ready = 1'b0; In_Valid = 1'b1; In_Data = 16'h5A5A;
    pre_en = 1'b0; pre_base = 16'd0;

    tick(); tick();
    @(negedge Clk);
    check("reset_outputs", all_outs(), 48'd0);
    tick();
    Reset = 1'b0; In_Valid = 1'b0;
    preload(16'h1000);

    // plain save, Out_Ready held high
    for (int i = 0; i < 8; i++) save_q.push_back(16'h1000 + 16'(i));
    busy_cnt = 0; done_cnt = 0;
    Out_Ready = 1'b1; Save_Req = 1'b1;
    tick();
    Save_Req = 1'b0;
    wait_done(40, cyc);
    check("save_done_latency", 48'(cyc), 48'd9);
    check("save_busy_cycles", 48'(busy_cnt), 48'd8);
    check("save_q_empty", 48'(save_q.size()), 48'd0);
    @(negedge Clk);
    check("done_single", 48'(Done), 48'd0);
    check("save_done_count", 48'(done_cnt), 48'd1);
    tick();

    // save with backpressure 1,0,0,1
    for (int i = 0; i < 8; i++) save_q.push_back(16'h1000 + 16'(i));
    Save_Req = 1'b1;
    tick();
    Save_Req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      Out_Ready = (k % 4 == 0) || (k % 4 == 3);
      @(negedge Clk);
      if (Done) seen = 1'b1;
      else tick();
    end
    check("bp_done_seen", 48'(seen), 48'd1);
    check("bp_q_empty", 48'(save_q.size()), 48'd0);
    tick();
    Out_Ready = 1'b0;

    // restore with In_Valid gaps
    for (int i = 0; i < 8; i++) wr_q.push_back({3'(i), 16'hA000 + 16'(i)});
    done_cnt = 0;
    Restore_Req = 1'b1;
    tick();
    Restore_Req = 1'b0;
    sent = 0; seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      In_Valid = k[0];
      In_Data  = 16'hA000 + 16'(sent);
      @(negedge Clk);
      if (Done) seen = 1'b1;
      else begin
        if (In_Valid && In_Ready) sent++;
        tick();
      end
    end
    check("restore_done_seen", 48'(seen), 48'd1);
    tick();
    In_Valid = 1'b0;
    for (int i = 0; i < 8; i++) check("restore_rf", 48'(rf[i]), 48'(16'hA000 + 16'(i)));
    tick();
    check("restore_done_count", 48'(done_cnt), 48'd1);
    check("restore_q_empty", 48'(wr_q.size()), 48'd0);

    // requests held while CPU busy, then CPU idles: save wins
    for (int i = 0; i < 8; i++) save_q.push_back(16'hA000 + 16'(i));
    Cpu_Idle = 1'b0; Save_Req = 1'b1; Restore_Req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("cpu_busy_hold", 48'(Busy), 48'd0);
      tick();
    end
    Cpu_Idle = 1'b1; Out_Ready = 1'b1;
    tick();
    Save_Req = 1'b0; Restore_Req = 1'b0;
    @(negedge Clk);
    check("both_req_save_valid", 48'(Out_Valid), 48'd1);
    check("both_req_no_restore", 48'(In_Ready), 48'd0);
    tick();
    Cpu_Idle = 1'b0;
    wait_done(40, cyc);
    check("cpu_drop_q_empty", 48'(save_q.size()), 48'd0);
    tick();
    Cpu_Idle = 1'b1; Out_Ready = 1'b0;

    // abort restore in the cycle of the third write
    preload(16'h1000);
    for (int i = 0; i < 3; i++) wr_q.push_back({3'(i), 16'hA000 + 16'(i)});
    done_cnt = 0;
    Restore_Req = 1'b1; In_Valid = 1'b1; In_Data = 16'hA000;
    tick();
    Restore_Req = 1'b0;
    tick();
    In_Data = 16'hA001;
    tick();
    In_Data = 16'hA002; Abort = 1'b1;
    tick();
    Abort = 1'b0; In_Valid = 1'b0;
    @(negedge Clk);
    check("abort_busy", 48'(Busy), 48'd0);
    check("abort_done", 48'(Done), 48'd0);
    tick(); tick();
    check("abort_done_count", 48'(done_cnt), 48'd0);
    check("abort_q_empty", 48'(wr_q.size()), 48'd0);
    for (int i = 0; i < 3; i++) check("abort_rf_written", 48'(rf[i]), 48'(16'hA000 + 16'(i)));
    for (int i = 3; i < 8; i++) check("abort_rf_kept", 48'(rf[i]), 48'(16'h1000 + 16'(i)));

    // reset mid-save at idx 4, with request and abort also high
    save_q.push_back(16'hA000); save_q.push_back(16'hA001);
    save_q.push_back(16'hA002); save_q.push_back(16'h1003);
    Out_Ready = 1'b1; Save_Req = 1'b1;
    tick();
    Save_Req = 1'b0;
    tick(); tick(); tick(); tick();
    Out_Ready = 1'b0; Reset = 1'b1; Save_Req = 1'b1; Abort = 1'b1;
    @(negedge Clk);
    check("pre_reset_idx", 48'(RF_SR2), 48'd4);
    tick();
    @(negedge Clk);
    check("midsave_reset_outputs", all_outs(), 48'd0);
    tick();
    Reset = 1'b0; Save_Req = 1'b0; Abort = 1'b0;
    check("midsave_q_empty", 48'(save_q.size()), 48'd0);
    save_q.push_back(16'hA000); save_q.push_back(16'hA001); save_q.push_back(16'hA002);
    for (int i = 3; i < 8; i++) save_q.push_back(16'h1000 + 16'(i));
    Out_Ready = 1'b1; Save_Req = 1'b1;
    tick();
    Save_Req = 1'b0;
    wait_done(40, cyc);
    check("restart_latency", 48'(cyc), 48'd9);
    check("restart_q_empty", 48'(save_q.size()), 48'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
